// File: rtl/dsp_result_sink.sv
// dsp_result_sink: tracks DSP48A1 issues through the slice pipeline, scales and saturates P,
// and buffers results in a credit-guarded show-ahead FIFO. Optional macro: DSP_SINK_ROUND_EN.
module dsp_result_sink #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned OUT_W   = 24,
  parameter int unsigned SHIFT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [47:0]      p_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [15:0]      sat_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = OUT_W + 1;
  localparam logic signed [48:0] SAT_MAX = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
  localparam logic signed [48:0] SAT_MIN = -(49'sd1 <<< (OUT_W - 1));

  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [15:0]        sat_count_q, sat_count_d;
  logic [EW-1:0]      mem_q [DEPTH];

  logic               issue_fire;
  logic               cap;
  logic               pop;
  logic signed [48:0] p_ext;
  logic signed [48:0] scaled;
  logic [OUT_W-1:0]   data_c;
  logic               sat_c;

  assign issue_fire  = issue_valid & issue_ready;
  assign cap         = vld_sr_q[LATENCY-1];
  assign pop         = out_valid & out_ready;
  // Credits cover both queued and in-flight results, so a capture always finds a free slot.
  assign issue_ready = ({1'b0, count_q} + {1'b0, inflight_q}) < SW'(DEPTH);
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q][OUT_W-1:0];
  assign out_sat     = mem_q[rd_ptr_q][OUT_W];
  assign sat_count   = sat_count_q;

  assign p_ext = {p_in[47], p_in};

`ifdef DSP_SINK_ROUND_EN
  if (SHIFT > 0) begin : g_round
    // 49-bit sum keeps the half-LSB bias from overflowing near full scale.
    assign scaled = (p_ext + (49'sd1 <<< (SHIFT - 1))) >>> SHIFT;
  end else begin : g_trunc
    assign scaled = p_ext >>> SHIFT;
  end
`else
  assign scaled = p_ext >>> SHIFT;
`endif

  // Saturate the scaled value into the signed OUT_W range.
  always_comb begin
    data_c = scaled[OUT_W-1:0];
    sat_c  = 1'b0;
    if (scaled > SAT_MAX) begin
      data_c = SAT_MAX[OUT_W-1:0];
      sat_c  = 1'b1;
    end else if (scaled < SAT_MIN) begin
      data_c = SAT_MIN[OUT_W-1:0];
      sat_c  = 1'b1;
    end
  end

  always_comb begin
    vld_sr_d    = LATENCY'(vld_sr_q << 1) | LATENCY'(issue_fire);
    inflight_d  = inflight_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sat_count_d = sat_count_q;
    if (issue_fire && !cap) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue_fire && cap) begin
      inflight_d = inflight_q - CW'(1);
    end
    if (cap && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!cap && pop) begin
      count_d = count_q - CW'(1);
    end
    if (cap) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (cap && sat_c && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr_q    <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sat_count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_sr_q    <= vld_sr_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sat_count_q <= sat_count_d;
      if (cap) begin
        mem_q[wr_ptr_q] <= {sat_c, data_c};
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(cap && (count_q == CW'(DEPTH))));

endmodule
